// File: rtl/seg_serial_rx.sv
// Receive side of the SEGLED serial link: deserialises a frame, latches it on PEN, flags bad lengths.
// Optional glyph-to-hex decode outputs are enabled by defining SEG_RX_DECODE_EN.
module seg_serial_rx #(
  parameter int WIDTH       = 64,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               SEGLED_CLK,
  input  logic               SEGLED_DO,
  input  logic               SEGLED_PEN,
  input  logic               SEGLED_CLR,
  output logic [WIDTH-1:0]   pattern,
  output logic               frame_valid,
  output logic               frame_err,
  output logic [CNT_W-1:0]   frame_cnt,
`ifdef SEG_RX_DECODE_EN
  output logic [WIDTH/2-1:0] data,
  output logic [WIDTH/8-1:0] digit_ok,
`endif
  output logic               busy
);

  localparam int BW = $clog2(WIDTH + 2);
  localparam logic [BW-1:0] CNT_FULL = BW'(WIDTH);
  localparam logic [BW-1:0] CNT_OVR  = BW'(WIDTH + 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_COMMIT = 2'd2} state_t;

  logic [SYNC_STAGES-1:0] clk_sync_r, do_sync_r, pen_sync_r, clr_sync_r;
  logic                   clk_d_r, pen_d_r;
  logic                   clk_rise_s, pen_rise_s, clr_n_s, do_s;
  logic [WIDTH-1:0]       shreg_r, pattern_r;
  logic [BW-1:0]          bit_cnt_r, bit_cnt_nxt_s;
  logic [CNT_W-1:0]       frame_cnt_r;
  logic                   frame_valid_r, frame_err_r, busy_r;
  state_t                 state_r;

  // Synchronisers for all four link inputs plus edge-detect delay flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_r <= '0;
      do_sync_r  <= '0;
      pen_sync_r <= '0;
      clr_sync_r <= '0;
      clk_d_r    <= 1'b0;
      pen_d_r    <= 1'b0;
    end else begin
      clk_sync_r <= {clk_sync_r[SYNC_STAGES-2:0], SEGLED_CLK};
      do_sync_r  <= {do_sync_r[SYNC_STAGES-2:0], SEGLED_DO};
      pen_sync_r <= {pen_sync_r[SYNC_STAGES-2:0], SEGLED_PEN};
      clr_sync_r <= {clr_sync_r[SYNC_STAGES-2:0], SEGLED_CLR};
      clk_d_r    <= clk_sync_r[SYNC_STAGES-1];
      pen_d_r    <= pen_sync_r[SYNC_STAGES-1];
    end
  end

  // Edge strobes and the saturating bit counter's next value
  always_comb begin
    do_s       = do_sync_r[SYNC_STAGES-1];
    clr_n_s    = clr_sync_r[SYNC_STAGES-1];
    clk_rise_s = clk_sync_r[SYNC_STAGES-1] & ~clk_d_r;
    pen_rise_s = pen_sync_r[SYNC_STAGES-1] & ~pen_d_r;
    if (clk_rise_s && (bit_cnt_r != CNT_OVR)) begin
      bit_cnt_nxt_s = bit_cnt_r + 1'b1;
    end else begin
      bit_cnt_nxt_s = bit_cnt_r;
    end
  end

  // Frame FSM: shift, commit or reject on the strobe, clear on CLR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      shreg_r       <= '0;
      bit_cnt_r     <= '0;
      pattern_r     <= '0;
      frame_cnt_r   <= '0;
      frame_valid_r <= 1'b0;
      frame_err_r   <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      frame_valid_r <= 1'b0;
      frame_err_r   <= 1'b0;
      if (!clr_n_s) begin
        state_r   <= ST_IDLE;
        shreg_r   <= '0;
        bit_cnt_r <= '0;
        busy_r    <= 1'b0;
      end else begin
        if (clk_rise_s) begin
          shreg_r <= {shreg_r[WIDTH-2:0], do_s};
        end
        case (state_r)
          ST_IDLE, ST_SHIFT: begin
            bit_cnt_r <= bit_cnt_nxt_s;
            if (pen_rise_s) begin
              state_r <= ST_COMMIT;
              busy_r  <= 1'b0;
            end else if (clk_rise_s) begin
              state_r <= ST_SHIFT;
              busy_r  <= 1'b1;
            end else begin
              state_r <= state_r;
              busy_r  <= busy_r;
            end
          end
          ST_COMMIT: begin
            if (bit_cnt_r == CNT_FULL) begin
              pattern_r     <= shreg_r;
              frame_valid_r <= 1'b1;
              frame_cnt_r   <= frame_cnt_r + 1'b1;
            end else begin
              frame_err_r <= 1'b1;
            end
            // A bit arriving during the commit cycle starts the next frame
            if (clk_rise_s) begin
              bit_cnt_r <= BW'(1);
              state_r   <= ST_SHIFT;
              busy_r    <= 1'b1;
            end else begin
              bit_cnt_r <= '0;
              state_r   <= ST_IDLE;
              busy_r    <= 1'b0;
            end
          end
          default: begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= '0;
            busy_r    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pattern     = pattern_r;
  assign frame_valid = frame_valid_r;
  assign frame_err   = frame_err_r;
  assign frame_cnt   = frame_cnt_r;
  assign busy        = busy_r;

`ifdef SEG_RX_DECODE_EN
  // Returns {recognised, nibble} for an active-low {g..a} glyph
  function automatic logic [4:0] glyph_decode(input logic [6:0] seg_n);
    logic [6:0] seg;
    seg = ~seg_n;
    case (seg)
      7'h3F:   glyph_decode = {1'b1, 4'h0};
      7'h06:   glyph_decode = {1'b1, 4'h1};
      7'h5B:   glyph_decode = {1'b1, 4'h2};
      7'h4F:   glyph_decode = {1'b1, 4'h3};
      7'h66:   glyph_decode = {1'b1, 4'h4};
      7'h6D:   glyph_decode = {1'b1, 4'h5};
      7'h7D:   glyph_decode = {1'b1, 4'h6};
      7'h07:   glyph_decode = {1'b1, 4'h7};
      7'h7F:   glyph_decode = {1'b1, 4'h8};
      7'h6F:   glyph_decode = {1'b1, 4'h9};
      7'h77:   glyph_decode = {1'b1, 4'hA};
      7'h7C:   glyph_decode = {1'b1, 4'hB};
      7'h39:   glyph_decode = {1'b1, 4'hC};
      7'h5E:   glyph_decode = {1'b1, 4'hD};
      7'h79:   glyph_decode = {1'b1, 4'hE};
      7'h71:   glyph_decode = {1'b1, 4'hF};
      default: glyph_decode = {1'b0, 4'h0};
    endcase
  endfunction

  logic [WIDTH/2-1:0] data_r;
  logic [WIDTH/8-1:0] digit_ok_r;

  // Decoded view of the committed pattern, one cycle behind it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r     <= '0;
      digit_ok_r <= '0;
    end else begin
      for (int k = 0; k < WIDTH / 8; k++) begin
        {digit_ok_r[k], data_r[4*k +: 4]} <= glyph_decode(pattern_r[8*k +: 7]);
      end
    end
  end

  assign data     = data_r;
  assign digit_ok = digit_ok_r;
`endif

endmodule

// File: tb/tb_seg_serial_rx.sv
// Randomised/directed bench for seg_serial_rx against a bit-queue reference model.
module tb_seg_serial_rx;
  localparam int WIDTH = 64;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic SEGLED_CLK = 1'b0, SEGLED_DO = 1'b0, SEGLED_PEN = 1'b0, SEGLED_CLR = 1'b1;
  logic [WIDTH-1:0] pattern;
  logic frame_valid, frame_err, busy;
  logic [CNT_W-1:0] frame_cnt;
`ifdef SEG_RX_DECODE_EN
  logic [WIDTH/2-1:0] data;
  logic [WIDTH/8-1:0] digit_ok;
`endif

  seg_serial_rx #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .SEGLED_CLK(SEGLED_CLK), .SEGLED_DO(SEGLED_DO), .SEGLED_PEN(SEGLED_PEN), .SEGLED_CLR(SEGLED_CLR),
    .pattern(pattern), .frame_valid(frame_valid), .frame_err(frame_err), .frame_cnt(frame_cnt),
`ifdef SEG_RX_DECODE_EN
    .data(data), .digit_ok(digit_ok),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int nvalid = 0, nerr = 0, nboth = 0;

  // reference model state
  bit q[$];
  logic [WIDTH-1:0] exp_pat = '0;
  logic [CNT_W-1:0] exp_cnt = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_valid) nvalid++;
      if (frame_err) nerr++;
      if (frame_valid && frame_err) nboth++;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // sends bits[n-1] first, 8-cycle half periods
  task automatic send_bits(input logic [127:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      SEGLED_DO = bits[i];
      tick(8);
      SEGLED_CLK = 1'b1;
      tick(8);
      SEGLED_CLK = 1'b0;
      if (SEGLED_CLR) q.push_back(bits[i]);
    end
    tick(4);
  endtask

  // strobe PEN, then check pulses and outputs against the model
  task automatic strobe(input string tag);
    int v0, e0;
    bit good;
    v0 = nvalid; e0 = nerr;
    good = (q.size() == WIDTH);
    if (good) begin
      exp_pat = '0;
      foreach (q[i]) exp_pat = {exp_pat[WIDTH-2:0], q[i]};
      exp_cnt = exp_cnt + 1'b1;
    end
    q.delete();
    SEGLED_PEN = 1'b1;
    tick(8);
    SEGLED_PEN = 1'b0;
    tick(6);
    chk({tag, "_valid"}, 128'(nvalid - v0), good ? 128'd1 : 128'd0);
    chk({tag, "_err"}, 128'(nerr - e0), good ? 128'd0 : 128'd1);
    chk({tag, "_pattern"}, 128'(pattern), 128'(exp_pat));
    chk({tag, "_cnt"}, 128'(frame_cnt), 128'(exp_cnt));
  endtask

  logic [127:0] rb;
  int len;
  int v0, e0;

  initial begin
    tick(3);
    chk("rst_pattern", 128'(pattern), 128'd0);
    chk("rst_valid", 128'(frame_valid), 128'd0);
    chk("rst_err", 128'(frame_err), 128'd0);
    chk("rst_cnt", 128'(frame_cnt), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    rst_n = 1'b1;
    tick(5);

    // clean frame with exact latency check
    send_bits(128'h0123456789ABCDEF, 64);
    chk("clean_busy", 128'(busy), 128'd1);
    exp_pat = 64'h0123456789ABCDEF;
    exp_cnt = exp_cnt + 1'b1;
    q.delete();
    SEGLED_PEN = 1'b1;
    tick(SYNC_STAGES + 1);
    chk("clean_early", 128'(frame_valid), 128'd0);
    tick(1);
    chk("clean_valid", 128'(frame_valid), 128'd1);
    chk("clean_pattern", 128'(pattern), 128'h0123456789ABCDEF);
    chk("clean_cnt", 128'(frame_cnt), 128'd1);
    tick(1);
    chk("clean_pulse", 128'(frame_valid), 128'd0);
    chk("clean_idle", 128'(busy), 128'd0);
    tick(6);
    SEGLED_PEN = 1'b0;
    tick(6);

    // short frame, then a normal frame
    rb = {$urandom, $urandom, $urandom, $urandom};
    send_bits(rb, 63);
    strobe("short");
    rb = {$urandom, $urandom, $urandom, $urandom};
    send_bits(rb, 64);
    strobe("after_short");

    // overrun
    rb = {$urandom, $urandom, $urandom, $urandom};
    send_bits(rb, 70);
    chk("ovr_bitcnt", 128'(dut.bit_cnt_r), 128'd65);
    strobe("overrun");

    // PEN with nothing received
    strobe("idle_pen");

    // clear mid-frame, PEN while clear is low
    rb = {$urandom, $urandom, $urandom, $urandom};
    send_bits(rb, 30);
    SEGLED_CLR = 1'b0;
    q.delete();
    tick(5);
    chk("clr_busy", 128'(busy), 128'd0);
    v0 = nvalid; e0 = nerr;
    SEGLED_PEN = 1'b1;
    tick(6);
    SEGLED_PEN = 1'b0;
    tick(6);
    chk("clr_pen_valid", 128'(nvalid - v0), 128'd0);
    chk("clr_pen_err", 128'(nerr - e0), 128'd0);
    chk("clr_pattern", 128'(pattern), 128'(exp_pat));
    SEGLED_CLR = 1'b1;
    tick(5);
    rb = {$urandom, $urandom, $urandom, $urandom};
    send_bits(rb, 64);
    strobe("post_clr");

    // async reset mid-frame
    rb = {$urandom, $urandom, $urandom, $urandom};
    send_bits(rb, 20);
    #3 rst_n = 1'b0;
    #1;
    chk("mrst_pattern", 128'(pattern), 128'd0);
    chk("mrst_cnt", 128'(frame_cnt), 128'd0);
    chk("mrst_busy", 128'(busy), 128'd0);
    q.delete();
    exp_pat = '0;
    exp_cnt = '0;
    tick(3);
    rst_n = 1'b1;
    tick(5);
    rb = {$urandom, $urandom, $urandom, $urandom};
    send_bits(rb, 64);
    strobe("post_rst");

    // random frame lengths
    for (int f = 0; f < 8; f++) begin
      len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 69)) : 64;
      rb = {$urandom, $urandom, $urandom, $urandom};
      send_bits(rb, len);
      strobe("rand");
    end

`ifdef SEG_RX_DECODE_EN
    begin
      logic [7:0] gl [16];
      logic [31:0] hexv;
      logic [63:0] fr;
      gl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
      hexv = 32'hDEADBEEF;
      for (int k = 0; k < 8; k++) fr[8*k +: 8] = gl[hexv[4*k +: 4]];
      send_bits(128'(fr), 64);
      strobe("glyph");
      chk("dec_data", 128'(data), 128'hDEADBEEF);
      chk("dec_ok", 128'(digit_ok), 128'hFF);
      fr[7:0] = 8'hFF;
      send_bits(128'(fr), 64);
      strobe("glyph_bad");
      chk("dec_bad_data", 128'(data), 128'hDEADBEE0);
      chk("dec_bad_ok", 128'(digit_ok), 128'hFE);
    end
`endif

    chk("never_both", 128'(nboth), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
